// File: rtl/onehot_decade_counter.sv
// One-hot decade counter digit: up/down stepping from an internal prescaler or a
// cascade carry, synchronous BCD load, wrap carry pulse and one-hot fault recovery.
module onehot_decade_counter #(
  parameter int unsigned DIV     = 50000000,
  parameter int unsigned DIV_W   = 26,
  parameter int unsigned CASCADE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up,
  input  logic             cin,
  input  logic             load,
  input  logic [3:0]       load_val,
  output logic [9:0]       hot,
  output logic             cout,
  output logic             load_err,
  output logic             fault
);

  localparam int unsigned DIGITS = 10;

  logic [DIGITS-1:0] hot_q, hot_d;
  logic [DIGITS-1:0] cur_hot;
  logic [DIV_W-1:0]  pre_q, pre_d;
  logic              cout_q, cout_d;
  logic              err_q, err_d;
  logic              fault_q, fault_d;
  logic              tick_c;
  logic              step_c;
  logic              legal_c;

  // Single observation point of the digit state; all next-state logic reads this.
  assign cur_hot = hot_q;

  assign tick_c  = (pre_q == DIV_W'(DIV - 1));
  assign step_c  = en & ((CASCADE != 0) ? cin : tick_c);
  assign legal_c = (cur_hot != '0) && ((cur_hot & (cur_hot - DIGITS'(1))) == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hot_q   <= DIGITS'(1);
      pre_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      hot_q   <= hot_d;
      pre_q   <= pre_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  // Priority: fault recovery, load, rejected load, step, hold.
  always_comb begin
    hot_d   = cur_hot;
    pre_d   = pre_q;
    cout_d  = 1'b0;
    err_d   = 1'b0;
    fault_d = fault_q;

    if (CASCADE != 0) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = tick_c ? '0 : pre_q + DIV_W'(1);
    end

    if (!legal_c) begin
      hot_d   = DIGITS'(1);
      fault_d = 1'b1;
    end else if (load) begin
      pre_d = '0;
      if (load_val <= 4'd9) begin
        hot_d = DIGITS'(1) << load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (step_c) begin
      if (up) begin
        hot_d  = {cur_hot[DIGITS-2:0], cur_hot[DIGITS-1]};
        cout_d = cur_hot[DIGITS-1];
      end else begin
        hot_d  = {cur_hot[0], cur_hot[DIGITS-1:1]};
        cout_d = cur_hot[0];
      end
    end
  end

  assign hot      = cur_hot;
  assign cout     = cout_q;
  assign load_err = err_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_onehot_decade_counter.sv
// Directed bench for onehot_decade_counter: prescaled digit, every-cycle digit and a
// cascaded upper digit fed by the every-cycle digit's carry.
module tb_onehot_decade_counter;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;

  logic [9:0] hot4, hot1, hot_hi;
  logic       cout4, cout1, cout_hi;
  logic       err4, err1, err_hi;
  logic       fault4, fault1, fault_hi;

  int errors = 0;
  int checks = 0;

  onehot_decade_counter #(.DIV(4), .DIV_W(3), .CASCADE(0)) dut4 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .cin(1'b0), .load(load),
    .load_val(load_val), .hot(hot4), .cout(cout4), .load_err(err4), .fault(fault4));

  onehot_decade_counter #(.DIV(1), .DIV_W(1), .CASCADE(0)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .cin(1'b0), .load(load),
    .load_val(load_val), .hot(hot1), .cout(cout1), .load_err(err1), .fault(fault1));

  onehot_decade_counter #(.DIV(1), .DIV_W(1), .CASCADE(1)) dut_hi (
    .clk(clk), .reset_n(reset_n), .en(en), .up(up), .cin(cout1), .load(load),
    .load_val(load_val), .hot(hot_hi), .cout(cout_hi), .load_err(err_hi), .fault(fault_hi));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] digit(input int d);
    logic [9:0] one;
    one = 10'd1;
    return one << d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; reset spans a quiet part of the cycle.
  task automatic do_reset();
    load = 1'b0;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0; reset_n = 1'b0;
    #12;
    checks++;
    if (hot1 !== 10'b0000000001 || cout1 !== 1'b0 || err1 !== 1'b0 || fault1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: hot=%b cout=%b err=%b fault=%b expected 0000000001 0 0 0",
               hot1, cout1, err1, fault1);
    end
    reset_n = 1'b1;
    step();
    en = 1'b1;
    for (int n = 0; n < 5; n++) step();
    checks++;
    if (hot1 !== 10'b0000100000) begin
      errors++;
      $display("FAIL pre_reset_count: hot=%b expected 0000100000", hot1);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (hot1 !== 10'b0000000001) begin
      errors++;
      $display("FAIL async_reset: hot=%b expected 0000000001", hot1);
    end
    en = 1'b0;
    #1;
    reset_n = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      checks++;
      if (hot1 !== 10'b0000000001 || cout1 !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold cyc%0d: hot=%b cout=%b expected 0000000001 0", n, hot1, cout1);
      end
    end
  endtask

  task automatic test_up_count();
    int pulses;
    pulses = 0;
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (cout4 === 1'b1) pulses++;
      checks++;
      if (hot4 !== digit((n / 4) % 10) || cout4 !== (n == 40)) begin
        errors++;
        $display("FAIL up_count edge%0d: hot=%b cout=%b expected %b %b",
                 n, hot4, cout4, digit((n / 4) % 10), (n == 40));
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL up_cout_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_down_count();
    do_reset();
    en = 1'b1; up = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      step();
      checks++;
      if (hot1 !== digit((10 - (n % 10)) % 10) || cout1 !== (n == 1 || n == 11)) begin
        errors++;
        $display("FAIL down_count edge%0d: hot=%b cout=%b expected %b %b",
                 n, hot1, cout1, digit((10 - (n % 10)) % 10), (n == 1 || n == 11));
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int n = 0; n < 3; n++) step();
    load = 1'b1; load_val = 4'd7;
    step();
    checks++;
    if (hot4 !== 10'b0010000000 || hot1 !== 10'b0010000000 || cout4 !== 1'b0 || cout1 !== 1'b0 ||
        err4 !== 1'b0) begin
      errors++;
      $display("FAIL load_over_step: hot4=%b hot1=%b cout4=%b cout1=%b err=%b expected 0010000000 x2, 0 0 0",
               hot4, hot1, cout4, cout1, err4);
    end
    load = 1'b0;
    step();
    checks++;
    if (hot1 !== digit(8) || hot4 !== digit(7)) begin
      errors++;
      $display("FAIL post_load_step: hot1=%b hot4=%b expected %b %b", hot1, hot4, digit(8), digit(7));
    end
    step(); step();
    checks++;
    if (hot4 !== digit(7)) begin
      errors++;
      $display("FAIL prescaler_cleared: hot4=%b expected %b", hot4, digit(7));
    end
    step();
    checks++;
    if (hot4 !== digit(8) || hot1 !== digit(1)) begin
      errors++;
      $display("FAIL post_load_tick: hot4=%b hot1=%b expected %b %b", hot4, hot1, digit(8), digit(1));
    end
    load = 1'b1; load_val = 4'hC;
    step();
    checks++;
    if (err4 !== 1'b1 || hot4 !== digit(8) || hot1 !== digit(1) || cout4 !== 1'b0) begin
      errors++;
      $display("FAIL bad_load: err=%b hot4=%b hot1=%b cout=%b expected 1 %b %b 0",
               err4, hot4, hot1, cout4, digit(8), digit(1));
    end
    load = 1'b0;
    step();
    checks++;
    if (err4 !== 1'b0 || hot4 !== digit(8)) begin
      errors++;
      $display("FAIL load_err_width: err=%b hot4=%b expected 0 %b", err4, hot4, digit(8));
    end
    step(); step(); step();
    checks++;
    if (hot4 !== digit(9)) begin
      errors++;
      $display("FAIL bad_load_clears_prescaler: hot4=%b expected %b", hot4, digit(9));
    end
  endtask

  task automatic test_cascade();
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (n == 10) begin
        checks++;
        if (cout1 !== 1'b1 || hot_hi !== digit(0)) begin
          errors++;
          $display("FAIL cascade_carry_latency: cout=%b hi=%b expected 1 %b", cout1, hot_hi, digit(0));
        end
      end
      if (n == 11) begin
        checks++;
        if (hot_hi !== digit(1)) begin
          errors++;
          $display("FAIL cascade_first_step: hi=%b expected %b", hot_hi, digit(1));
        end
      end
    end
    checks++;
    if (hot1 !== digit(5) || hot_hi !== 10'b0000000100) begin
      errors++;
      $display("FAIL cascade_final: lo=%b hi=%b expected %b 0000000100", hot1, hot_hi, digit(5));
    end
  endtask

  task automatic test_fault();
    do_reset();
    en = 1'b1; up = 1'b1;
    checks++;
    if (fault4 !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: fault=%b expected 0", fault4);
    end
    force dut4.cur_hot = 10'b0000000110;
    step();
    release dut4.cur_hot;
    #1;
    checks++;
    if (hot4 !== 10'b0000000001 || fault4 !== 1'b1 || cout4 !== 1'b0 || err4 !== 1'b0) begin
      errors++;
      $display("FAIL fault_recover: hot=%b fault=%b cout=%b err=%b expected 0000000001 1 0 0",
               hot4, fault4, cout4, err4);
    end
    for (int n = 0; n < 12; n++) begin
      step();
      checks++;
      if (fault4 !== 1'b1) begin
        errors++;
        $display("FAIL fault_sticky cyc%0d: fault=%b expected 1", n, fault4);
      end
    end
    checks++;
    if (hot4 !== digit(3)) begin
      errors++;
      $display("FAIL count_after_fault: hot=%b expected %b", hot4, digit(3));
    end
    do_reset();
    checks++;
    if (fault4 !== 1'b0 || hot4 !== digit(0)) begin
      errors++;
      $display("FAIL fault_reset: fault=%b hot=%b expected 0 %b", fault4, hot4, digit(0));
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_cascade();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
